chan_select_pipe: RTL and testbench
===================================

# chan_select_pipe

Parametrised, registered N-to-1 channel selector with a valid/ready handshake, a low-active LSB force input, and an optional auto-scan mode. It is the pipelined, generalised successor of the fixed 6-to-1 select/NOT/OR path. It sits between the multi-channel sample bus and downstream consumers that apply backpressure, and it flags out-of-range selects.

## Interface
- NCH, 6, number of input channels (≥2)
- W, 4, channel data width in bits (≥1)
- SELW, derived localparam = $clog2(NCH), select/pointer width; not overridable
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  request to transfer one beat
- in_ready  output  1  block can accept a beat this cycle
- sel  input  SELW  requested channel (fixed mode)
- data_in  input  NCH*W  channel c occupies bits [c*W +: W]
- set_n  input  1  when 0, forces out_data[0]=1 for the accepted beat
- scan_mode  input  1  1 = auto-scan, 0 = fixed select (present only with CHSEL_SCAN_EN)
- out_valid  output  1  out_data/out_sel hold a beat
- out_ready  input  1  consumer accepts the beat
- out_data  output  W  selected data, OR'd with force
- out_sel  output  SELW  channel index that produced out_data
- err_range  output  1  sticky: an accepted beat had sel ≥ NCH
- err_clr  input  1  synchronous clear of err_range

## Operation
- One-entry output register. in_ready = !out_valid || out_ready (combinational).
- Accept = in_valid && in_ready. On accept, ch = scan ? ptr : sel.
- out_data <= (ch < NCH ? data_in[ch*W +: W] : '0) | {{W-1{1'b0}}, ~set_n}. out_sel <= ch. out_valid <= 1.
- No accept and out_ready high: out_valid <= 0. Data and sel registers keep their value.
- While out_valid && !out_ready: out_data and out_sel are held stable and no beat is accepted.
- err_range: set on an accepted beat with ch ≥ NCH (fixed mode only). Cleared by err_clr. Set wins when both occur in the same cycle.
- Scan pointer ptr (SELW bits) advances by 1 on each scan-mode accept and wraps from NCH-1 to 0. ptr can never be ≥ NCH.
- A rising edge of scan_mode (registered compare) resets ptr to 0. The beat accepted in that same cycle uses channel 0.
- Switching modes never drops or corrupts a pending output beat.

## Timing
- Reset values: out_valid=0, out_data=0, out_sel=0, err_range=0, ptr=0, scan_mode history=0.
- An asserted reset discards any pending beat immediately.
- Latency: accept in cycle N produces out_valid in cycle N+1.
- Throughput: 1 beat/cycle while out_ready=1.
- in_ready falls in the same cycle that out_valid=1 && out_ready=0.
- err_range updates one cycle after the accepting or clearing edge.
- Non-power-of-two NCH: sel values NCH..2^SELW-1 produce zero data plus err_range.

## Configuration
- CHSEL_SCAN_EN defined: scan_mode port, ptr counter and edge detect are compiled in.
- CHSEL_SCAN_EN undefined: no scan_mode port and no ptr counter; the block always runs in fixed-select mode.
- Handshake, force and err_range behaviour are identical in both builds.

## Structure
- chsel_pkg holds:
  - default localparams CHSEL_NCH_DEF=6 and CHSEL_W_DEF=4
  - function chsel_pick(data, ch, nch, w), returning the zero-defaulted slice
- Sub-module chsel_scan_ctr (under CHSEL_SCAN_EN) contains:
  - ptr with wrap at NCH-1
  - scan_mode edge detect
  - advance input driven by the accept strobe
- Top-level holds the handshake register, force OR and err_range.

## Test plan
- Reset: assert rst_n=0 mid-stream → all outputs 0 asynchronously; after release, in_ready=1.
- Fixed select, NCH=6, W=4: data_in channel c = c+8, set_n=1, sel=0..7 streamed with out_ready=1. Required response:
  - out_data = 8..13 for sel=0..5, then 0,0 for sel=6,7
  - out_sel equals sel, one cycle later
  - err_range=1 after the sel=6 beat
- Force: sel=2, data_in[2]=4'b0100, set_n=0 → out_data=4'b0101. With set_n=1 → 4'b0100.
- Backpressure: hold out_ready=0 for 3 cycles with out_valid=1 → out_data and out_sel stable and in_ready=0. Release → next beat appears the following cycle with no loss or duplication.
- err_clr with simultaneous sel=7 accept → err_range stays 1. err_clr alone → err_range=0 next cycle.
- Scan (CHSEL_SCAN_EN): raise scan_mode and send 8 beats → out_sel = 0,1,2,3,4,5,0,1 and err_range stays 0. Drop and re-raise scan_mode → next out_sel=0.

Source files
------------

// File: rtl/chsel_pkg.sv
// Shared defaults and the zero-defaulted channel slice helper for chan_select_pipe.
package chsel_pkg;

    localparam int CHSEL_NCH_DEF  = 6;
    localparam int CHSEL_W_DEF    = 4;
    localparam int CHSEL_DATA_MAX = 256;
    localparam int CHSEL_W_MAX    = 32;

    // Channel slice [ch*w +: w] of data, or zero when ch is not a real channel.
    function automatic logic [CHSEL_W_MAX-1:0] chsel_pick(
        input logic [CHSEL_DATA_MAX-1:0] data,
        input int unsigned               ch,
        input int unsigned               nch,
        input int unsigned               w
    );
        logic [CHSEL_DATA_MAX-1:0] shifted;
        logic [CHSEL_W_MAX-1:0]    res;
        res     = '0;
        shifted = data >> (ch * w);
        if (ch < nch) begin
            for (int unsigned b = 0; b < CHSEL_W_MAX; b++) begin
                if (b < w) begin
                    res[b] = shifted[b];
                end else begin
                    res[b] = 1'b0;
                end
            end
        end else begin
            res = '0;
        end
        return res;
    endfunction

endpackage

// File: rtl/chan_select_pipe_if.sv
// Sample-bus side and consumer side handshake bundle of chan_select_pipe.
interface chan_select_pipe_if
    import chsel_pkg::*;
#(
    parameter int NCH = CHSEL_NCH_DEF,
    parameter int W   = CHSEL_W_DEF
);
    localparam int SELW = $clog2(NCH);

    logic               in_valid;
    logic               in_ready;
    logic [SELW-1:0]    sel;
    logic [NCH*W-1:0]   data_in;
    logic               set_n;
    logic               out_valid;
    logic               out_ready;
    logic [W-1:0]       out_data;
    logic [SELW-1:0]    out_sel;

    modport slave (
        input  in_valid, sel, data_in, set_n, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );

    modport master (
        output in_valid, sel, data_in, set_n, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

endinterface

// File: rtl/chsel_scan_ctr.sv
// Auto-scan channel pointer with scan_mode rising-edge restart (built only with CHSEL_SCAN_EN).
module chsel_scan_ctr #(
    parameter int NCH  = 6,
    parameter int SELW = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            scan_mode,
    input  logic            advance,
    output logic [SELW-1:0] ptr
);
    logic [SELW-1:0] ptr_q, ptr_d;
    logic            scan_hist_q, scan_hist_d;
    logic            rise_s;
    logic [SELW-1:0] ptr_eff_s;

    // A fresh scan_mode rise restarts at channel 0 for the beat taken in that same cycle.
    always_comb begin
        rise_s      = scan_mode & ~scan_hist_q;
        scan_hist_d = scan_mode;
        if (rise_s) begin
            ptr_eff_s = '0;
        end else begin
            ptr_eff_s = ptr_q;
        end
        if (advance && scan_mode) begin
            if (ptr_eff_s == SELW'(NCH - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = ptr_eff_s + SELW'(1);
            end
        end else begin
            ptr_d = ptr_eff_s;
        end
    end

    // Pointer and scan_mode history registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            scan_hist_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            scan_hist_q <= scan_hist_d;
        end
    end

    assign ptr = ptr_eff_s;

endmodule

// File: rtl/chan_select_pipe.sv
// Registered N-to-1 channel selector with valid/ready handshake, LSB force and sticky range error.
// Optional auto-scan mode compiled in with macro CHSEL_SCAN_EN.
module chan_select_pipe
    import chsel_pkg::*;
#(
    parameter int NCH = CHSEL_NCH_DEF,
    parameter int W   = CHSEL_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef CHSEL_SCAN_EN
    input  logic               scan_mode,
`endif
    chan_select_pipe_if.slave  bus,
    output logic               err_range,
    input  logic               err_clr
);
    localparam int SELW = $clog2(NCH);

    logic                      out_valid_q, out_valid_d;
    logic [W-1:0]              out_data_q, out_data_d;
    logic [SELW-1:0]           out_sel_q, out_sel_d;
    logic                      err_range_q, err_range_d;

    logic                      in_ready_s;
    logic                      accept_s;
    logic                      scan_s;
    logic [SELW-1:0]           ch_s;
    logic                      ch_oor_s;
    logic [CHSEL_DATA_MAX-1:0] data_ext_s;
    logic [CHSEL_W_MAX-1:0]    pick_s;
    logic [W-1:0]              force_s;

`ifdef CHSEL_SCAN_EN
    logic [SELW-1:0]           ptr_s;

    chsel_scan_ctr #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_scan_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .scan_mode (scan_mode),
        .advance   (accept_s),
        .ptr       (ptr_s)
    );

    assign scan_s = scan_mode;
`else
    assign scan_s = 1'b0;
`endif

    assign in_ready_s = ~out_valid_q | bus.out_ready;
    assign accept_s   = bus.in_valid & in_ready_s;

    // Channel choice, slice extraction and force bit.
    always_comb begin
`ifdef CHSEL_SCAN_EN
        if (scan_s) begin
            ch_s = ptr_s;
        end else begin
            ch_s = bus.sel;
        end
`else
        ch_s = bus.sel;
`endif
        ch_oor_s   = (32'(ch_s) >= 32'(NCH));
        data_ext_s = '0;
        data_ext_s[NCH*W-1:0] = bus.data_in;
        pick_s     = chsel_pick(data_ext_s, 32'(ch_s), 32'(NCH), 32'(W));
        force_s    = '0;
        force_s[0] = ~bus.set_n;
    end

    // Output register next state; data/sel only move on an accepted beat.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (accept_s) begin
            out_valid_d = 1'b1;
            out_data_d  = pick_s[W-1:0] | force_s;
            out_sel_d   = ch_s;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Sticky range error; a new violation outranks a clear in the same cycle.
    always_comb begin
        if (accept_s && !scan_s && ch_oor_s) begin
            err_range_d = 1'b1;
        end else if (err_clr) begin
            err_range_d = 1'b0;
        end else begin
            err_range_d = err_range_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            err_range_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            err_range_q <= err_range_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
    assign err_range     = err_range_q;

endmodule

// File: tb/tb_chan_select_pipe.sv
// Directed self-checking bench for chan_select_pipe (NCH=6, W=4).
module tb_chan_select_pipe;

    localparam int NCH  = 6;
    localparam int W    = 4;
    localparam int SELW = $clog2(NCH);

    logic clk = 1'b0;
    logic rst_n;
    logic err_range;
    logic err_clr;
`ifdef CHSEL_SCAN_EN
    logic scan_mode;
`endif

    int tests = 0;
    int fails = 0;

    chan_select_pipe_if #(.NCH(NCH), .W(W)) bus ();

    chan_select_pipe #(.NCH(NCH), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef CHSEL_SCAN_EN
        .scan_mode (scan_mode),
`endif
        .bus       (bus.slave),
        .err_range (err_range),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_default_data();
        for (int c = 0; c < NCH; c++) begin
            bus.data_in[c*W +: W] = W'(c + 8);
        end
    endtask

    initial begin
        logic [W-1:0] exp_d;
        rst_n         = 1'b1;
        err_clr       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.sel       = '0;
        bus.set_n     = 1'b1;
        bus.out_ready = 1'b1;
        load_default_data();
`ifdef CHSEL_SCAN_EN
        scan_mode     = 1'b0;
`endif
        #2;
        rst_n = 1'b0;
        step();
        step();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data",  32'(bus.out_data),  32'd0);
        chk("rst_out_sel",   32'(bus.out_sel),   32'd0);
        chk("rst_err_range", 32'(err_range),     32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);

        // Fixed-select sweep over sel=0..7
        bus.in_valid = 1'b1;
        for (int s = 0; s < 8; s++) begin
            bus.sel = SELW'(s);
            step();
            exp_d = (s < NCH) ? W'(s + 8) : W'(0);
            chk($sformatf("sweep_valid_%0d", s), 32'(bus.out_valid), 32'd1);
            chk($sformatf("sweep_data_%0d", s),  32'(bus.out_data),  32'(exp_d));
            chk($sformatf("sweep_sel_%0d", s),   32'(bus.out_sel),   32'(s));
            chk($sformatf("sweep_err_%0d", s),   32'(err_range),     (s >= NCH) ? 32'd1 : 32'd0);
        end

        // Force LSB
        bus.data_in[2*W +: W] = 4'b0100;
        bus.sel   = 3'd2;
        bus.set_n = 1'b0;
        step();
        chk("force_on",  32'(bus.out_data), 32'h5);
        bus.set_n = 1'b1;
        step();
        chk("force_off", 32'(bus.out_data), 32'h4);
        load_default_data();

        // Drain, then backpressure
        bus.in_valid = 1'b0;
        step();
        chk("drain_valid", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.sel       = 3'd3;
        step();
        chk("bp_first_data", 32'(bus.out_data), 32'hB);
        bus.sel = 3'd4;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp_in_ready_%0d", k), 32'(bus.in_ready), 32'd0);
            step();
            chk($sformatf("bp_valid_%0d", k), 32'(bus.out_valid), 32'd1);
            chk($sformatf("bp_data_%0d", k),  32'(bus.out_data),  32'hB);
            chk($sformatf("bp_sel_%0d", k),   32'(bus.out_sel),   32'd3);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
        step();
        chk("bp_next_data", 32'(bus.out_data), 32'hC);
        chk("bp_next_sel",  32'(bus.out_sel),  32'd4);
        bus.in_valid = 1'b0;
        step();
        chk("bp_no_dup_valid", 32'(bus.out_valid), 32'd0);
        chk("bp_hold_data",    32'(bus.out_data),  32'hC);

        // err_clr against a simultaneous out-of-range accept, then alone
        err_clr      = 1'b1;
        bus.in_valid = 1'b1;
        bus.sel      = 3'd7;
        step();
        chk("clr_vs_set_err",  32'(err_range),    32'd1);
        chk("clr_vs_set_data", 32'(bus.out_data), 32'd0);
        bus.in_valid = 1'b0;
        step();
        chk("clr_alone_err", 32'(err_range), 32'd0);
        err_clr = 1'b0;
        step();
        chk("clr_stays_err", 32'(err_range), 32'd0);

        // Mid-stream asynchronous reset
        bus.in_valid = 1'b1;
        bus.sel      = 3'd6;
        step();
        bus.sel = 3'd1;
        step();
        chk("pre_rst_err",  32'(err_range),    32'd1);
        chk("pre_rst_data", 32'(bus.out_data), 32'h9);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("async_rst_data",  32'(bus.out_data),  32'd0);
        chk("async_rst_sel",   32'(bus.out_sel),   32'd0);
        chk("async_rst_err",   32'(err_range),     32'd0);
        bus.in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 32'(bus.in_ready), 32'd1);

`ifdef CHSEL_SCAN_EN
        // Auto-scan: sel input is ignored, pointer wraps after NCH-1
        scan_mode    = 1'b1;
        bus.sel      = 3'd7;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("scan_sel_%0d", i),  32'(bus.out_sel),  32'(i % NCH));
            chk($sformatf("scan_data_%0d", i), 32'(bus.out_data), 32'((i % NCH) + 8));
            chk($sformatf("scan_err_%0d", i),  32'(err_range),    32'd0);
        end
        scan_mode    = 1'b0;
        bus.in_valid = 1'b0;
        step();
        scan_mode    = 1'b1;
        bus.in_valid = 1'b1;
        step();
        chk("scan_restart_sel", 32'(bus.out_sel), 32'd0);
        bus.in_valid = 1'b0;
        scan_mode    = 1'b0;
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
